axis_rr_arb: RTL
================

# axis_rr_arb

Packet-granular round-robin arbiter that merges N AXI-stream slave inputs onto one AXI-stream master output. It sits upstream of a stream sink such as the FIFO-backed stream slave adapter, sharing that single consumer between several producers. A grant is held from a packet's first beat through the beat carrying `tlast`, so packets are never interleaved. The output is registered, giving full throughput inside a packet.

## Interface
- `N`, 4: number of input streams, ≥1.
- `WIDTH`, 32: tdata width per stream.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `s_axis_tdata` input N*WIDTH: input `i` occupies bits `[i*WIDTH +: WIDTH]`.
- `s_axis_tvalid` input N: per-input valid.
- `s_axis_tready` output N: per-input ready; at most one bit set per cycle.
- `s_axis_tlast` input N: per-input end of packet.
- `m_axis_tdata` output WIDTH: merged data.
- `m_axis_tvalid` output 1: merged valid.
- `m_axis_tready` input 1: downstream ready.
- `m_axis_tlast` output 1: merged end of packet.
- `m_axis_tid` output IDW=max(1,$clog2(N)): source index of the current output beat. Present only with `AXIS_RR_ARB_TID_EN`.
- `grant` output N: one-hot index of the locked input, or 0 in IDLE.

## Operation
- The FSM has two states: IDLE and LOCK.
- **IDLE:**
  - All `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is 1, select the first requester at or above `ptr`, wrapping from N-1 to 0. Register it into `grant`/`gidx` and go to LOCK.
  - With no requester, remain in IDLE.
- **LOCK:**
  - `s_axis_tready[gidx] = ~m_axis_tvalid | m_axis_tready`. All other ready bits are 0.
  - A beat is accepted when `s_axis_tvalid[gidx] & s_axis_tready[gidx]`. It loads the output register with `{tlast, tdata, gidx}` and sets `m_axis_tvalid`.
  - Accepting a beat with `tlast=1` sets `ptr = (gidx+1) mod N`, clears `grant` and returns to IDLE.
  - If the granted input drops `tvalid` mid-packet, the lock holds and no other input is served.
- **Output register:**
  - `m_axis_tvalid` clears when the downstream accepts (`m_axis_tvalid & m_axis_tready`) and no new beat is loaded the same cycle.
  - Output contents stay stable while `m_axis_tvalid & ~m_axis_tready`.
- Non-granted inputs are ignored regardless of their `tvalid`.
- N=1: `ptr` stays 0 and operation is otherwise identical.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant`=0, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tid`=0.
- Arbitration takes 1 cycle: a request seen in IDLE at cycle t gives `s_axis_tready` at t+1.
- Latency from input acceptance to `m_axis_tvalid` is 1 cycle.
- Throughput is 1 beat/cycle within a packet while `m_axis_tready`=1.
- There is exactly 1 idle input cycle (the IDLE arbitration cycle) between packets. The output register may still be draining during that cycle.
- A single-beat packet (`tlast` on the first beat) spends 1 cycle in LOCK.
- When the downstream accepts a beat and a new beat is loaded in the same cycle, the new beat wins and `m_axis_tvalid` stays 1.
- `rst` asserted mid-packet: all outputs return to reset values on the next edge and the partial packet is discarded. Upstream must also be reset.

## Configuration
- `AXIS_RR_ARB_TID_EN` defined: the `m_axis_tid` port exists and carries `gidx`, registered alongside the data.
- `AXIS_RR_ARB_TID_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package `axis_arb_pkg` holds:
  - typedef `arb_state_t` (IDLE, LOCK);
  - the IDW computation function.
- Sub-module `rr_pick`: combinational, parameter `N`. Inputs are `req[N]` and `ptr`. Outputs are the one-hot `gnt[N]`, `gidx` and `any`. It rotates requests by `ptr`, applies a priority encoder, and rotates back.
- The top level holds the FSM, `ptr`, the grant registers, the ready generation, the data mux and the output register.

## Test plan
- **Single source:** N=4, input 2 sends 3 beats 0xA0..0xA2 with tlast on 0xA2, m_tready=1. Output is 0xA0,0xA1,0xA2 on consecutive cycles, tlast on the 3rd, and tid=2 when enabled.
- **All request:** inputs 0..3 all valid with 2-beat packets from reset. Grant order is 0,1,2,3,0, with 1 idle input cycle between packets.
- **Fairness wrap:** after serving input 3, inputs 0 and 3 both request. Input 0 is granted.
- **Backpressure:** m_tready=0 for 5 cycles mid-packet. m_tdata is held, s_tready drops the cycle after the register fills, and no beat is lost or duplicated.
- **Mid-packet stall:** granted input 1 drops tvalid for 3 cycles while input 0 is valid. Input 0 gets no ready, and input 1's packet completes first.
- **Reset mid-packet:** rst asserted during beat 2 of 4. On the next edge m_tvalid=0, grant=0 and ptr=0. The first post-reset grant goes to the lowest valid input.

Source files
------------

// File: rtl/axis_rr_arb_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : axis_arb_pkg                                                     |
// | Brief    : Shared types and helpers for the axis_rr_arb stream arbiter.     |
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

package axis_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Index width for N sources; a single source still gets a 1-bit index.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_arb_rr_pick.sv
// +-----------------------------------------------------------------------------+
// | Module   : rr_pick                                                          |
// | Brief    : Combinational round-robin picker: rotate, priority-encode,      |
// |            rotate back. Returns one-hot grant, its index and any-request.   |
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int  N   = 4,
  localparam int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gidx,
  output logic           any
);

  logic [N-1:0]   w_req_rot;
  logic [IDW-1:0] w_rot_idx;

  always_comb begin
    w_req_rot = '0;
    for (int p = 0; p < N; p++) begin
      if (ptr == IDW'(p)) begin
        for (int i = 0; i < N; i++) begin
          w_req_rot[i] = req[(i + p) % N];
        end
      end
    end

    // Lowest rotated position wins, i.e. the first requester at or above ptr.
    w_rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_rot_idx = IDW'(i);
      end
    end
    any = |w_req_rot;

    gnt  = '0;
    gidx = '0;
    for (int p = 0; p < N; p++) begin
      if (ptr == IDW'(p)) begin
        for (int i = 0; i < N; i++) begin
          if (any && (w_rot_idx == IDW'(i))) begin
            gnt[(i + p) % N] = 1'b1;
            gidx             = IDW'((i + p) % N);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arb.sv
// +-----------------------------------------------------------------------------+
// | Module   : axis_rr_arb                                                      |
// | Brief    : Packet-granular round-robin merge of N AXI-stream inputs onto  |
// |            one registered output. Define AXIS_RR_ARB_TID_EN for m_axis_tid.|
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module axis_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  WIDTH = 32,
  localparam int IDW   = calc_idw(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   s_axis_tdata,
  input  logic [N-1:0]         s_axis_tvalid,
  output logic [N-1:0]         s_axis_tready,
  input  logic [N-1:0]         s_axis_tlast,
  output logic [WIDTH-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
`ifdef AXIS_RR_ARB_TID_EN
  output logic [IDW-1:0]       m_axis_tid,
`endif
  output logic [N-1:0]         grant
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDW-1:0]   gidx_q, gidx_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
`ifdef AXIS_RR_ARB_TID_EN
  logic [IDW-1:0]   m_tid_q, m_tid_d;
`endif

  logic [N-1:0]     w_pick_gnt;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_any;
  logic [N-1:0]     w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req  (s_axis_tvalid),
    .ptr  (ptr_q),
    .gnt  (w_pick_gnt),
    .gidx (w_pick_idx),
    .any  (w_pick_any)
  );

  // grant_q is one-hot on the locked input, so it doubles as the ready mask.
  always_comb begin
    w_ready = '0;
    if ((state_q == ST_LOCK) && (!m_valid_q || m_axis_tready)) begin
      w_ready = grant_q;
    end
    w_accept = |(s_axis_tvalid & w_ready);
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        w_sel_data = s_axis_tdata[i*WIDTH +: WIDTH];
        w_sel_last = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          state_d = ST_LOCK;
          grant_d = w_pick_gnt;
          gidx_d  = w_pick_idx;
        end
      end
      ST_LOCK: begin
        if (w_accept && w_sel_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == IDW'(N - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // A fresh beat takes priority over draining, keeping tvalid high back-to-back.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
`ifdef AXIS_RR_ARB_TID_EN
    m_tid_d   = m_tid_q;
`endif
    if (w_accept) begin
      m_valid_d = 1'b1;
      m_last_d  = w_sel_last;
      m_data_d  = w_sel_data;
`ifdef AXIS_RR_ARB_TID_EN
      m_tid_d   = gidx_q;
`endif
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
`ifdef AXIS_RR_ARB_TID_EN
      m_tid_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
`ifdef AXIS_RR_ARB_TID_EN
      m_tid_q   <= m_tid_d;
`endif
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign grant         = grant_q;
`ifdef AXIS_RR_ARB_TID_EN
  assign m_axis_tid    = m_tid_q;
`endif

endmodule

`default_nettype wire
